// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the sliced adder sequencer: FSM state encoding,
// default geometry and the slice-index width helper.
package adder_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_SIZE   = 4;
    localparam int DEF_SLICES = 4;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/adder_parameted.sv
// Combinational slice adder: {o_c, o_s} = a + b + i_c at size+1 bits.
module adder_parameted
    import adder_seq_ctrl_pkg::*;
#(
    parameter int size = DEF_SIZE
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            i_c,
    output logic [size-1:0] o_s,
    output logic            o_c
);

    assign {o_c, o_s} = {1'b0, a} + {1'b0, b} + {{size{1'b0}}, i_c};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle wide adder: walks SLICES slices of SIZE bits LSB-first through
// one adder_parameted instance, carry registered between slices.
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int SLICES = DEF_SLICES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIZE*SLICES-1:0] in_a,
    input  logic [SIZE*SLICES-1:0] in_b,
    input  logic                   in_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE*SLICES-1:0] out_sum,
    output logic                   out_c,
    output logic                   busy
);

    localparam int W     = SIZE * SLICES;
    localparam int IDX_W = idx_width(SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [SIZE-1:0]  slice_a, slice_b, slice_s;
    logic             slice_c;

    assign slice_a = a_q[int'(idx_q)*SIZE +: SIZE];
    assign slice_b = b_q[int'(idx_q)*SIZE +: SIZE];

    adder_parameted #(
        .size (SIZE)
    ) u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .i_c (carry_q),
        .o_s (slice_s),
        .o_c (slice_c)
    );

    // Partial sums build up in acc_q; out_sum only moves when a whole result
    // is ready, so the previous result stays visible during the next RUN.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_c;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                acc_d[int'(idx_q)*SIZE +: SIZE] = slice_s;
                carry_d = slice_c;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    sum_d   = acc_d;
                    cout_d  = slice_c;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign out_sum = sum_q;
    assign out_c   = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Self-checking bench for adder_seq_ctrl: directed vectors, backpressure,
// mid-operation reset, back-to-back throughput and a random sweep.
module tb_adder_seq_ctrl;

    localparam int SIZE   = 4;
    localparam int SLICES = 4;
    localparam int W      = SIZE * SLICES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b;
    logic         in_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_c;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(
        .SIZE   (SIZE),
        .SLICES (SLICES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .busy      (busy)
    );

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand pair, waits for acceptance, then for out_valid.
    // lat is the cycle number of the first out_valid, counting the cycle
    // right after the accept edge as 1.
    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           output int lat, output bit to);
        int guard;
        to = 1'b0;
        lat = 0;
        in_a = a;
        in_b = b;
        in_c = c;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            to = 1'b1;
            return;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!out_valid) to = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_c = 1'b0;
        out_ready = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy, out_c, out_sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%0b vld=%0b busy=%0b c=%0b sum=%h, want 1 0 0 0 0000",
                     in_ready, out_valid, busy, out_c, out_sum);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h8000, 16'hFFFF};
        logic [W-1:0] tb[5] = '{16'h0000, 16'h0001, 16'h4321, 16'h8000, 16'hFFFF};
        logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W:0]   te[5] = '{17'h00000, 17'h10000, 17'h05556, 17'h10000, 17'h1FFFF};
        int lat;
        bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_op(ta[i], tb[i], tc[i], lat, to);
            n_tests++;
            if (to || lat != SLICES + 1) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got cycle %0d (timeout=%0b), want %0d",
                         i, lat, to, SLICES + 1);
            end
            n_tests++;
            if ({out_c, out_sum} !== te[i]) begin
                n_fail++;
                $display("FAIL directed_sum[%0d]: got %h, want %h", i, {out_c, out_sum}, te[i]);
            end
            if (i == 0) begin
                n_tests++;
                if ({busy, in_ready} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL done_flags: got busy=%0b rdy=%0b, want 1 0", busy, in_ready);
                end
            end
            step();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_pulse[%0d]: out_valid got %0b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        out_ready = 1'b0;
        send_op(16'h00FF, 16'h0001, 1'b0, lat, to);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (to || {out_valid, in_ready, out_c, out_sum} !== {1'b1, 1'b0, 1'b0, 16'h0100}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got vld=%0b rdy=%0b c=%0b sum=%h, want 1 0 0 0100",
                         k, out_valid, in_ready, out_c, out_sum);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_tests++;
        if ({out_valid, in_ready, out_c, out_sum} !== {1'b0, 1'b1, 1'b0, 16'h0100}) begin
            n_fail++;
            $display("FAIL backpressure_release: got vld=%0b rdy=%0b c=%0b sum=%h, want 0 1 0 0100",
                     out_valid, in_ready, out_c, out_sum);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit to;
        bit seen;
        out_ready = 1'b1;
        in_a = 16'hFFFF;
        in_b = 16'h0001;
        in_c = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy, out_c, out_sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL midrun_reset: got rdy=%0b vld=%0b busy=%0b c=%0b sum=%h, want 1 0 0 0 0000",
                     in_ready, out_valid, busy, out_c, out_sum);
        end
        step();
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_after: got stray_valid=%0b rdy=%0b, want 0 1", seen, in_ready);
        end
        send_op(16'h0005, 16'h0003, 1'b0, lat, to);
        n_tests++;
        if (to || {out_c, out_sum} !== 17'h00008) begin
            n_fail++;
            $display("FAIL midrun_next_op: got %h (timeout=%0b), want 00008", {out_c, out_sum}, to);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[3], qb[3];
        logic         qc[3];
        logic [W:0]   expq[$];
        logic [W:0]   exp_v;
        int  sent, got, cyc, last_cyc;
        logic acc;
        for (int i = 0; i < 3; i++) begin
            qa[i] = W'($urandom);
            qb[i] = W'($urandom);
            qc[i] = 1'($urandom);
            expq.push_back(model(qa[i], qb[i], qc[i]));
        end
        out_ready = 1'b1;
        sent = 0;
        got = 0;
        cyc = 0;
        last_cyc = -1;
        in_a = qa[0];
        in_b = qb[0];
        in_c = qc[0];
        in_valid = 1'b1;
        while (got < 3 && cyc < 100) begin
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 3) begin
                    in_a = qa[sent];
                    in_b = qb[sent];
                    in_c = qc[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                exp_v = expq.pop_front();
                n_tests++;
                if ({out_c, out_sum} !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_sum[%0d]: got %h, want %h", got, {out_c, out_sum}, exp_v);
                end
                if (last_cyc >= 0) begin
                    n_tests++;
                    if (cyc - last_cyc != SLICES + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d",
                                 got, cyc - last_cyc, SLICES + 2);
                    end
                end
                last_cyc = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results, want 3", got);
        end
        step();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   exp_v;
        int lat, hold;
        bit to;
        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            exp_v = model(a, b, c);
            hold = $urandom_range(0, 2);
            out_ready = (hold == 0);
            send_op(a, b, c, lat, to);
            n_tests++;
            if (to || {out_c, out_sum} !== exp_v) begin
                n_fail++;
                $display("FAIL random_sum[%0d]: a=%h b=%h c=%0b got %h (timeout=%0b), want %h",
                         i, a, b, c, {out_c, out_sum}, to, exp_v);
            end
            for (int k = 0; k < hold; k++) begin
                step();
                n_tests++;
                if (!out_valid || {out_c, out_sum} !== exp_v) begin
                    n_fail++;
                    $display("FAIL random_hold[%0d]: vld=%0b got %h, want 1 %h",
                             i, out_valid, {out_c, out_sum}, exp_v);
                end
            end
            out_ready = 1'b1;
            step();
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
